// File: rtl/dram_line_responder.sv
// Memory-side line responder: one request at a time, 512-bit lines moved as
// 8 x 64-bit beats. Reads return after a fixed latency; writes commit after the 8th beat.
module dram_line_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int OFFSET         = 6,
  parameter int INDEX_BITS     = 6,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
  localparam int MEM_LINES = 2 ** INDEX_BITS;
  localparam int BEAT_W    = $clog2(LINE_BEATS);
  localparam int LAT_W     = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {IDLE, ACK, WR_WAIT, WR_ACK, COMMIT, LAT, RESP} state_t;

  state_t                                      state_q, state_d;
  logic [BEAT_W-1:0]                           beat_q, beat_d;
  logic [LAT_W-1:0]                            lat_q, lat_d;
  logic [INDEX_BITS-1:0]                       idx_q, idx_d;
  logic [BUS_TAG_WIDTH-1:0]                    tag_q, tag_d;
  logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0]   buf_q;
  logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0]   mem_q [MEM_LINES];
  logic                                        buf_load, buf_wr, mem_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
    end
  end

  // Line buffer and backing store; a reset mid-write drops the partial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
      for (int i = 0; i < MEM_LINES; i++) mem_q[i] <= '0;
    end else begin
      if (buf_load)    buf_q         <= mem_q[idx_q];
      else if (buf_wr) buf_q[beat_q] <= bus_req;
      if (mem_wr)      mem_q[idx_q]  <= buf_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;
    mem_wr      = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    unique case (state_q)
      IDLE: if (bus_reqcyc) begin
        idx_d   = bus_req[OFFSET+INDEX_BITS-1:OFFSET];
        tag_d   = bus_reqtag;
        state_d = ACK;
      end
      ACK: begin
        bus_reqack = 1'b1;
        beat_d     = '0;
        if (tag_q[BUS_TAG_WIDTH-1]) begin
          buf_load = 1'b1;
          // LAT burns exactly LATENCY cycles, so it is skipped entirely at zero.
          if (LATENCY == 0) state_d = RESP;
          else begin
            lat_d   = LAT_W'(LATENCY - 1);
            state_d = LAT;
          end
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: if (bus_reqcyc) begin
        buf_wr  = 1'b1;
        state_d = WR_ACK;
      end
      WR_ACK: begin
        bus_reqack = 1'b1;
        if (beat_q == LAST_BEAT) state_d = COMMIT;
        else begin
          beat_d  = beat_q + BEAT_W'(1);
          state_d = WR_WAIT;
        end
      end
      COMMIT: begin
        mem_wr  = 1'b1;
        state_d = IDLE;
      end
      LAT: begin
        if (lat_q == '0) state_d = RESP;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      RESP: begin
        bus_respcyc = 1'b1;
        bus_resp    = buf_q[beat_q];
        bus_resptag = tag_q;
        if (bus_respack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dram_line_responder.sv
// Directed bench for dram_line_responder: latency-4 instance for the main
// traffic plus a latency-0 instance for the zero-latency path.
module tb_dram_line_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc, reqack, respcyc, respack;
  logic [63:0] req, resp;
  logic [12:0] reqtag, resptag;
  logic        r0_reqcyc, r0_reqack, r0_respcyc, r0_respack;
  logic [63:0] r0_req, r0_resp;
  logic [12:0] r0_reqtag, r0_resptag;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dram_line_responder dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(reqcyc), .bus_reqack(reqack), .bus_req(req), .bus_reqtag(reqtag),
    .bus_respcyc(respcyc), .bus_respack(respack), .bus_resp(resp), .bus_resptag(resptag)
  );

  dram_line_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .bus_reqcyc(r0_reqcyc), .bus_reqack(r0_reqack), .bus_req(r0_req), .bus_reqtag(r0_reqtag),
    .bus_respcyc(r0_respcyc), .bus_respack(r0_respack), .bus_resp(r0_resp), .bus_resptag(r0_resptag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write a line holding reqcyc high throughout; returns ack count and back-to-back acks.
  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                          input logic [7:0][63:0] d, output int acks, output int b2b);
    logic prev;
    acks = 0; b2b = 0; prev = 1'b0;
    reqcyc = 1'b1; req = addr; reqtag = tag;
    for (int c = 0; c < 60 && acks < 9; c++) begin
      tick();
      if (reqack) begin
        if (prev) b2b++;
        acks++;
        if (acks < 9) req = d[acks-1];
        else reqcyc = 1'b0;
      end
      prev = reqack;
    end
    reqcyc = 1'b0; req = '0; reqtag = '0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                         input logic [7:0][63:0] exp, input int stall_beat,
                         input int stall_n, input string nm);
    int n;
    logic got;
    reqcyc = 1'b1; req = addr; reqtag = tag;
    tick();
    chk({nm, "_ack"}, 64'(reqack), 64'd1);
    reqcyc = 1'b0; req = '0; reqtag = '0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = respcyc;
    end
    chk({nm, "_lat"}, 64'(n), 64'd5);
    if (got) begin
      for (int i = 0; i < 8; i++) begin
        if (i == stall_beat)
          for (int s = 0; s < stall_n; s++) begin
            respack = 1'b0;
            chk({nm, "_stall_data"}, resp, exp[i]);
            chk({nm, "_stall_tag"}, 64'(resptag), 64'(tag));
            tick();
          end
        chk({nm, "_cyc"}, 64'(respcyc), 64'd1);
        chk({nm, "_data"}, resp, exp[i]);
        chk({nm, "_tag"}, 64'(resptag), 64'(tag));
        respack = 1'b1;
        tick();
      end
      respack = 1'b0;
      chk({nm, "_done"}, 64'(respcyc), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0][63:0] da, db, z;
    int acks, b2b, n;
    for (int i = 0; i < 8; i++) begin
      da[i] = 64'(i + 1) * 64'h11;
      db[i] = 64'hBEEF_0000_0000_0000 | 64'(i * 3 + 1);
    end
    z = '0;
    reset = 1'b0;
    reqcyc = 1'b0; respack = 1'b0; req = '0; reqtag = '0;
    r0_reqcyc = 1'b0; r0_respack = 1'b0; r0_req = '0; r0_reqtag = '0;
    tick();
    tick();
    chk("rst_reqack", 64'(reqack), 64'd0);
    chk("rst_respcyc", 64'(respcyc), 64'd0);
    chk("rst_resp", resp, 64'd0);
    chk("rst_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    tick();

    // unwritten line reads as zero
    do_read(64'h140, 13'h1002, z, -1, 0, "rd_blank");

    // write 0x40 with reqcyc held high, then read it back
    do_write(64'h40, 13'h0005, da, acks, b2b);
    chk("wr_acks", 64'(acks), 64'd9);
    chk("wr_b2b", 64'(b2b), 64'd0);
    chk("wr_idle_ack", 64'(reqack), 64'd0);
    do_read(64'h40, 13'h1005, da, -1, 0, "rd_basic");

    // response stall on beat 2
    do_read(64'h40, 13'h1007, da, 2, 3, "rd_stall");

    // alias: 0x1040 maps to index 1 as well; address bits [5:0] ignored on read
    do_write(64'h1040, 13'h0009, db, acks, b2b);
    chk("alias_acks", 64'(acks), 64'd9);
    do_read(64'h7F, 13'h100A, db, -1, 0, "rd_alias");

    // reset during beat 3 of a read
    reqcyc = 1'b1; req = 64'h40; reqtag = 13'h1001;
    tick();
    reqcyc = 1'b0;
    n = 0;
    while (!respcyc && n < 20) begin tick(); n++; end
    respack = 1'b1;
    tick(); tick(); tick();
    chk("mid_beat3", resp, db[3]);
    reset = 1'b0;
    respack = 1'b0;
    tick();
    chk("mid_rst_respcyc", 64'(respcyc), 64'd0);
    chk("mid_rst_reqack", 64'(reqack), 64'd0);
    reset = 1'b1;
    tick();
    do_read(64'h40, 13'h1003, z, -1, 0, "rd_after_rst");

    // zero-latency instance: respcyc the cycle after reqack
    r0_reqcyc = 1'b1; r0_req = 64'h80; r0_reqtag = 13'h1003;
    tick();
    chk("l0_ack", 64'(r0_reqack), 64'd1);
    r0_reqcyc = 1'b0;
    tick();
    chk("l0_respcyc", 64'(r0_respcyc), 64'd1);
    chk("l0_resptag", 64'(r0_resptag), 64'h1003);
    chk("l0_resp", r0_resp, 64'd0);
    r0_respack = 1'b1;
    repeat (8) tick();
    r0_respack = 1'b0;
    chk("l0_done", 64'(r0_respcyc), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
